// File: rtl/mt_pkg.sv
// Shared constants and helpers for the multithreaded fetch front end.
// The datapath and imem stages use the same defaults and thread-id width rule.
package mt_pkg;

  localparam int N_THREADS_DEF     = 4;
  localparam int PC_WIDTH_DEF      = 64;
  localparam int THREAD_STRIDE_DEF = 'h100;

  // A thread id is at least one bit wide, even for a single-thread build.
  function automatic int tid_width(input int n_threads);
    return (n_threads <= 1) ? 1 : $clog2(n_threads);
  endfunction

endpackage

// File: rtl/mt_pc_unit_if.sv
// Fetch-side bundle of the PC unit: thread control and redirect in, fetch address out.
// The pipeline side drives master; the PC unit is the slave.
interface mt_pc_unit_if
  import mt_pkg::*;
#(
  parameter int N_THREADS = N_THREADS_DEF,
  parameter int PC_WIDTH  = PC_WIDTH_DEF
);

  localparam int TID_W = tid_width(N_THREADS);

  logic                 stall;
  logic [N_THREADS-1:0] thread_en;
  logic                 redirect_valid;
  logic [TID_W-1:0]     redirect_tid;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic                 fetch_valid;
  logic [TID_W-1:0]     fetch_tid;
  logic [PC_WIDTH-1:0]  fetch_pc;

  modport master (
    output stall, thread_en, redirect_valid, redirect_tid, redirect_pc,
    input  fetch_valid, fetch_tid, fetch_pc
  );

  modport slave (
    input  stall, thread_en, redirect_valid, redirect_tid, redirect_pc,
    output fetch_valid, fetch_tid, fetch_pc
  );

endinterface

// File: rtl/mt_pc_unit_rr_thread_sel.sv
// Round-robin thread picker: the first enabled thread after cur_tid in cyclic
// order, with cur_tid itself considered last.
module rr_thread_sel
  import mt_pkg::*;
#(
  parameter int N_THREADS = N_THREADS_DEF,
  localparam int TID_W    = tid_width(N_THREADS)
) (
  input  logic [TID_W-1:0]     cur_tid,
  input  logic [N_THREADS-1:0] thread_en,
  output logic [TID_W-1:0]     next_tid,
  output logic                 any_en
);

  assign any_en = |thread_en;

  if (N_THREADS == 1) begin : g_single
    assign next_tid = '0;
  end else begin : g_multi
    logic [TID_W-1:0] idx;
    logic             found;

    // Power-of-two thread count, so the TID_W-bit sum wraps around the ring.
    always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      next_tid = cur_tid;
      found    = 1'b0;
      idx      = '0;
      for (int k = 1; k <= N_THREADS; k++) begin
        idx = cur_tid + TID_W'(k);
        if (!found && thread_en[idx]) begin
          next_tid = idx;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mt_pc_unit.sv
// Multithreaded program-counter unit: one PC per hardware thread, round-robin
// thread selection, post-increment on fetch, per-thread redirect, global stall.
module mt_pc_unit
  import mt_pkg::*;
#(
  parameter int                  N_THREADS     = N_THREADS_DEF,
  parameter int                  PC_WIDTH      = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] PC_INC        = PC_WIDTH'(1),
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [PC_WIDTH-1:0] THREAD_STRIDE = PC_WIDTH'(THREAD_STRIDE_DEF)
) (
  input logic         clk,
  input logic         rst,
  mt_pc_unit_if.slave bus
);

  localparam int TID_W = tid_width(N_THREADS);

  logic [PC_WIDTH-1:0] pc_reg [N_THREADS];
  logic [TID_W-1:0]    cur_tid;
  logic [TID_W-1:0]    next_tid;
  logic                any_en;
  logic                fetch_valid;

  rr_thread_sel #(
    .N_THREADS (N_THREADS)
  ) u_sel (
    .cur_tid   (cur_tid),
    .thread_en (bus.thread_en),
    .next_tid  (next_tid),
    .any_en    (any_en)
  );

  assign fetch_valid     = bus.thread_en[cur_tid];
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_tid   = cur_tid;
  assign bus.fetch_pc    = pc_reg[cur_tid];

  // Redirect beats the fetch increment; an out-of-range redirect_tid matches no thread.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: pc_reg is a small flop array, not a RAM, so resetting every entry is intended.
      for (int t = 0; t < N_THREADS; t++) begin
        pc_reg[t] <= RESET_PC + PC_WIDTH'(t) * THREAD_STRIDE;
      end
    end else begin
      for (int t = 0; t < N_THREADS; t++) begin
        // NOTE: non-blocking so every entry updates from the same pre-edge state.
        if (bus.redirect_valid && int'(bus.redirect_tid) == t) begin
          pc_reg[t] <= bus.redirect_pc;
        end else if (!bus.stall && fetch_valid && int'(cur_tid) == t) begin
          pc_reg[t] <= pc_reg[t] + PC_INC;
        end
      end
    end
  end

  // With no thread enabled the selector has nothing to move to, so cur_tid holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_tid <= '0;
    end else if (!bus.stall && any_en) begin
      cur_tid <= next_tid;
    end
  end

endmodule

// File: tb/tb_mt_pc_unit.sv
// Bench for mt_pc_unit: directed vector table, async-reset sequence, then
// randomized traffic against a behavioural model of the thread/PC rules.
module tb_mt_pc_unit;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  mt_pc_unit_if #(.N_THREADS(4), .PC_WIDTH(64)) bus ();

  mt_pc_unit #(
    .N_THREADS     (4),
    .PC_WIDTH      (64),
    .PC_INC        (64'd1),
    .RESET_PC      (64'd0),
    .THREAD_STRIDE (64'h100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [3:0]  en;
    logic        rv;
    logic [1:0]  rtid;
    logic [63:0] rpc;
    logic        ev;
    logic [1:0]  etid;
    logic [63:0] epc;
  } vec_t;

  vec_t vecs[29];

  // Behavioural model state
  logic [63:0] mpc[4];
  int          mtid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(input logic s, input logic [3:0] en, input logic rv,
                              input logic [1:0] rtid, input logic [63:0] rpc,
                              input logic ev, input logic [1:0] etid, input logic [63:0] epc);
    vec_t v;
    v.stall = s; v.en = en; v.rv = rv; v.rtid = rtid; v.rpc = rpc;
    v.ev = ev; v.etid = etid; v.epc = epc;
    return v;
  endfunction

  task automatic drive(input logic s, input logic [3:0] en, input logic rv,
                       input logic [1:0] rtid, input logic [63:0] rpc);
    bus.stall          = s;
    bus.thread_en      = en;
    bus.redirect_valid = rv;
    bus.redirect_tid   = rtid;
    bus.redirect_pc    = rpc;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [1:0] etid,
                           input logic [63:0] epc);
    check({tag, ".valid"}, 64'(bus.fetch_valid), 64'(ev));
    check({tag, ".tid"},   64'(bus.fetch_tid),   64'(etid));
    check({tag, ".pc"},    bus.fetch_pc,         epc);
  endtask

  task automatic model_reset();
    for (int t = 0; t < 4; t++) mpc[t] = 64'(t) * 64'h100;
    mtid = 0;
  endtask

  // Applies one clock edge's worth of the rules to the model.
  task automatic model_step(input logic s, input logic [3:0] en, input logic rv,
                            input logic [1:0] rtid, input logic [63:0] rpc);
    logic fv;
    logic found;
    int   cand;
    fv = en[mtid];
    for (int t = 0; t < 4; t++) begin
      if (rv && int'(rtid) == t) mpc[t] = rpc;
      else if (!s && fv && t == mtid) mpc[t] = mpc[t] + 64'd1;
    end
    if (!s) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        cand = (mtid + k) % 4;
        if (!found && en[cand]) begin
          mtid  = cand;
          found = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 4'hF, 0, 0, 0,         1, 0, 64'h000);
    vecs[1]  = mk(0, 4'hF, 0, 0, 0,         1, 1, 64'h100);
    vecs[2]  = mk(0, 4'hF, 0, 0, 0,         1, 2, 64'h200);
    vecs[3]  = mk(0, 4'hF, 0, 0, 0,         1, 3, 64'h300);
    vecs[4]  = mk(0, 4'hF, 0, 0, 0,         1, 0, 64'h001);
    vecs[5]  = mk(1, 4'hF, 0, 0, 0,         1, 1, 64'h101);
    vecs[6]  = mk(1, 4'hF, 0, 0, 0,         1, 1, 64'h101);
    vecs[7]  = mk(1, 4'hF, 0, 0, 0,         1, 1, 64'h101);
    vecs[8]  = mk(0, 4'hF, 0, 0, 0,         1, 1, 64'h101);
    vecs[9]  = mk(0, 4'hF, 1, 2, 64'h4000,  1, 2, 64'h201);
    vecs[10] = mk(1, 4'hF, 1, 3, 64'h50,    1, 3, 64'h301);
    vecs[11] = mk(0, 4'hF, 0, 0, 0,         1, 3, 64'h050);
    vecs[12] = mk(0, 4'hF, 0, 0, 0,         1, 0, 64'h002);
    vecs[13] = mk(0, 4'hF, 0, 0, 0,         1, 1, 64'h102);
    vecs[14] = mk(0, 4'hF, 0, 0, 0,         1, 2, 64'h4000);
    vecs[15] = mk(0, 4'h5, 0, 0, 0,         0, 3, 64'h051);
    vecs[16] = mk(0, 4'h5, 0, 0, 0,         1, 0, 64'h003);
    vecs[17] = mk(0, 4'h5, 0, 0, 0,         1, 2, 64'h4001);
    vecs[18] = mk(0, 4'h0, 0, 0, 0,         0, 0, 64'h004);
    vecs[19] = mk(0, 4'h0, 0, 0, 0,         0, 0, 64'h004);
    vecs[20] = mk(0, 4'h5, 1, 0, ONES,      1, 0, 64'h004);
    vecs[21] = mk(0, 4'h5, 0, 0, 0,         1, 2, 64'h4002);
    vecs[22] = mk(0, 4'h5, 0, 0, 0,         1, 0, ONES);
    vecs[23] = mk(0, 4'h5, 0, 0, 0,         1, 2, 64'h4003);
    vecs[24] = mk(0, 4'h5, 0, 0, 0,         1, 0, 64'h000);
    vecs[25] = mk(0, 4'h2, 0, 0, 0,         0, 2, 64'h4004);
    vecs[26] = mk(0, 4'h2, 0, 0, 0,         1, 1, 64'h103);
    vecs[27] = mk(0, 4'h2, 0, 0, 0,         1, 1, 64'h104);
    vecs[28] = mk(0, 4'hF, 0, 0, 0,         1, 1, 64'h105);

    // Directed table from a fresh reset
    rst = 1'b0;
    drive(0, 4'hF, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].stall, vecs[i].en, vecs[i].rv, vecs[i].rtid, vecs[i].rpc);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].etid, vecs[i].epc);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges, then resume from reset PCs
    drive(0, 4'hF, 1, 2, 64'h7777);
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 1'b1, 2'd0, 64'h000);
    @(negedge clk);
    check_out("async_hold", 1'b1, 2'd0, 64'h000);
    drive(0, 4'hF, 0, 0, 0);
    rst = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #1;
      check_out($sformatf("post_rst%0d", t), 1'b1, 2'(t % 4),
                (t == 4) ? 64'h001 : 64'(t) * 64'h100);
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the model
    rst = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic        s;
      logic [3:0]  en;
      logic        rv;
      logic [1:0]  rtid;
      logic [63:0] rpc;
      s    = ($urandom_range(0, 3) == 0);
      en   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      rv   = ($urandom_range(0, 9) < 3);
      rtid = 2'($urandom_range(0, 3));
      rpc  = ($urandom_range(0, 3) == 0) ? ONES - 64'($urandom_range(0, 2))
                                         : {$urandom, $urandom};
      drive(s, en, rv, rtid, rpc);
      #1;
      check_out($sformatf("rand%0d", i), en[mtid], 2'(mtid), mpc[mtid]);
      model_step(s, en, rv, rtid, rpc);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mt_pc_unit.md
Name: mt_pc_unit

Overview:
- Multithreaded program-counter unit for the fetch stage.
- Holds one PC per hardware thread and selects one thread per cycle by round-robin over the enabled threads.
- Presents that thread's PC to instruction memory and post-increments it.
- Later pipeline stages can redirect any thread's PC (branch/jump); a pipeline stall freezes fetch.

Parameters:
N_THREADS, 4, number of hardware threads (power of two, 1..16)
PC_WIDTH, 64, width of each PC
PC_INC, 1, increment applied to the fetched thread's PC (word-addressed imem)
RESET_PC, 0, reset PC of thread 0
THREAD_STRIDE, 'h100, reset PC of thread t = RESET_PC + t*THREAD_STRIDE

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
stall  in  1  freeze fetch: no increment, no thread advance
thread_en  in  N_THREADS  per-thread enable mask; disabled threads are skipped
redirect_valid  in  1  load redirect_pc into thread redirect_tid
redirect_tid  in  TID_W  target thread of redirect
redirect_pc  in  PC_WIDTH  new PC value
fetch_valid  out  1  fetch_pc/fetch_tid are a real fetch this cycle
fetch_tid  out  TID_W  thread selected this cycle
fetch_pc  out  PC_WIDTH  PC of selected thread (imem address)

Behaviour:
- TID_W = max(1, clog2(N_THREADS)).
- State: pc_reg[0..N_THREADS-1] and cur_tid. Outputs are combinational from state plus thread_en:
  - fetch_tid = cur_tid
  - fetch_pc = pc_reg[cur_tid]
  - fetch_valid = thread_en[cur_tid]
- Reset (rst=0, asynchronous):
  - pc_reg[t] = RESET_PC + t*THREAD_STRIDE, truncated to PC_WIDTH.
  - cur_tid = 0.
  - Hence fetch_tid=0, fetch_pc=RESET_PC, fetch_valid=thread_en[0].
  - Reset deassertion takes effect at the first following rising edge. Reset mid-run discards all redirects and progress.
- Per rising edge, for each thread t, pc_reg[t] update priority, first match wins:
  1. redirect_valid && redirect_tid==t: pc_reg[t] <= redirect_pc. Applies regardless of stall or thread_en.
  2. !stall && fetch_valid && t==cur_tid: pc_reg[t] <= pc_reg[t] + PC_INC, modulo 2^PC_WIDTH. All-ones + 1 wraps to 0.
  3. Otherwise hold.
- Redirect to the thread fetched this cycle overrides its increment. Next time that thread is selected, fetch_pc = redirect_pc exactly.
- Thread advance:
  - If stall=1, cur_tid holds.
  - Otherwise cur_tid <= first t in cyclic order cur_tid+1, cur_tid+2, ..., cur_tid (self last) with thread_en[t]=1.
  - If no bit of thread_en is set, cur_tid holds and fetch_valid=0.
  - With only one enabled thread, it is selected every cycle.
- Latency:
  - Redirect is visible on fetch_pc one cycle later, if that thread is selected then.
  - A thread re-enabled via thread_en is eligible at the next advance decision.
- A disabled thread keeps its PC and resumes from it when re-enabled.
- redirect_tid >= N_THREADS (non-power-of-two use is disallowed): ignored.
- stall and redirect in the same cycle: redirect applies, nothing else changes.

Decomposition:
- Shared package mt_pkg: TID_W function/constant, default N_THREADS, PC_WIDTH, THREAD_STRIDE. The datapath and imem stages reuse these.
- One natural sub-module: rr_thread_sel.
  - Inputs: cur_tid, thread_en.
  - Outputs: next_tid, any_en.
  - Purely combinational cyclic priority search.
- mt_pc_unit holds the PC register file and update logic.

Test Plan:
All cases use defaults: N=4, PC_INC=1, stride 'h100.
1. Reset, thread_en=4'b1111, no stall/redirect. Fetches over 8 cycles: (0,0x000), (1,0x100), (2,0x200), (3,0x300), (0,0x001), (1,0x101), (2,0x201), (3,0x301).
2. thread_en=4'b0101 after reset. Fetches alternate (0,0x000), (2,0x200), (0,0x001), (2,0x201); thread 1 and 3 PCs unchanged. thread_en=0 -> fetch_valid=0 and cur_tid held.
3. stall=1 for 3 cycles mid-run at (1,0x101). fetch_tid/fetch_pc stay (1,0x101) throughout. On release, PC1 becomes 0x102 and thread 2 follows.
4. Redirect tid=2 pc=0x4000 while cur_tid=2, no stall. Next fetch of thread 2 shows 0x4000, not 0x201. Redirect tid=3 pc=0x50 during stall=1: thread 3 later fetches 0x50.
5. Redirect tid=0 pc=all-ones, then fetch thread 0. Next thread-0 fetch is 0x0, i.e. wrap.
6. Assert rst=0 asynchronously between edges mid-run. Outputs immediately (0,RESET_PC) and all PCs return to reset values; resumes correctly after release.
